spram_initiator: RTL and testbench
==================================

# spram_initiator

Initiator-side controller for a single-port, read-first RAM with a registered one-cycle read output. It accepts a valid/ready request stream of reads and writes and drives the RAM's `write_en`/`read_en`/`address`/`data_in` port. It captures `data_out` and returns read data in order on a valid/ready response stream, buffered against backpressure. After reset it can clear the whole RAM to a constant before taking requests.

## Interface
- DATA_WIDTH, 8, RAM word width.
- DEPTH, 256, number of RAM words.
- RESP_DEPTH, 4, response FIFO entries; must be at least 2.
- INIT_EN, 1, 1 = clear the RAM after reset; 0 = skip the clear.
- INIT_VALUE, 0, word written during the clear.
- ADDR_W (localparam), max(1, clog2(DEPTH)).

Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clk edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  clear finished; requests may be accepted.
- ram_write_en  out  1  to RAM write_en.
- ram_read_en  out  1  to RAM read_en.
- ram_address  out  ADDR_W  to RAM address; upper bits are tied to 0 at integration.
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_data_out  in  DATA_WIDTH  from RAM data_out; registered and read-first.

## Operation
- **State machine:** two states, CLEAR and RUN.
  - Reset enters CLEAR when INIT_EN=1, otherwise RUN.
  - CLEAR: an address counter runs 0..DEPTH-1, one RAM write of INIT_VALUE per cycle. The cycle after the DEPTH-1 write, the FSM moves to RUN.
  - init_done = (state == RUN). req_ready is 0 in CLEAR.
- **Accept rule:** req_ready = RUN && (outstanding < RESP_DEPTH).
  - outstanding counts reads accepted but not yet popped; width clog2(RESP_DEPTH+1).
  - It is checked for reads and writes alike, so ordering stays simple.
- **Write accepted:** next cycle ram_write_en=1 with ram_address=req_addr and ram_data_in=req_wdata. No response is generated.
- **Read accepted:** next cycle ram_read_en=1 with ram_address=req_addr.
  - A pending flag follows the read one stage.
  - The cycle after the strobe, ram_data_out is pushed into the response FIFO.
- **Out-of-range address (req_addr ≥ DEPTH):** no RAM strobe.
  - Write: dropped silently.
  - Read: still occupies the pipeline and pushes 0.
- **outstanding counter:** +1 on read accept, −1 on pop (resp_valid && resp_ready). Both on the same edge: unchanged.
- **FIFO:** never overflows, guaranteed by the credit check. resp_valid = FIFO not empty. resp_rdata = head entry, registered.
- **RAM strobes:** at most one strobe per cycle, and never ram_write_en && ram_read_en together.
- **Inactive RAM outputs:** when no strobe is driven, ram_address and ram_data_in hold their last value.
- **Reset mid-operation:** flushes the pipeline, FIFO and counters. In-flight reads are lost and the clear restarts from address 0.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, init_done 0, ram_write_en 0, ram_read_en 0, ram_address 0, ram_data_in 0.
- With INIT_EN=0, init_done and req_ready rise the first cycle after rst falls.
- With INIT_EN=1:
  - The first clear write is driven the first cycle after rst falls.
  - init_done rises DEPTH cycles after that.
- Read latency: accept at edge E0, ram_read_en during (E0,E1], FIFO push at E2, resp_valid high after E2. That is 2 cycles from accept to resp_valid.
- Throughput: 1 request per cycle while resp_ready=1.
- With resp_ready=0, at most RESP_DEPTH reads are accepted, then req_ready drops.
- Write to address A followed by a read of A in the next accepted request: the read returns the new data, since the RAM write edge precedes the read edge.
- Pop and push in the same cycle on a one-entry FIFO: the head advances to the new entry, with no bubble.

## Test plan
- INIT_EN=1, DEPTH=16, INIT_VALUE=0xA5: release reset, read addresses 0..15 → every response is 0xA5, and init_done rises exactly 16 cycles after the first clear write.
- Back-to-back writes 0x11 to 0x3 and 0x22 to 0x4, then reads of 0x3 and 0x4 with resp_ready=1 → responses 0x11, 0x22 in order; each resp_valid is 2 cycles after its accept; no bubbles.
- resp_ready=0 with 6 reads offered, RESP_DEPTH=4 → exactly 4 accepted, then req_ready=0. Raise resp_ready → the 4 responses drain in order and the remaining 2 reads are accepted.
- DEPTH=12: write 0x7F to address 13, then read address 13 → no ram_write_en/ram_read_en pulse, response is 0; read address 11 → normal data.
- Assert rst with 3 reads in flight → after reset no stale resp_valid appears, outstanding=0, and the clear sweep restarts at address 0.
- Random mixed traffic checked against a scoreboard → no cycle with both RAM enables high, and the response order matches the request order.

Source files
------------

// File: rtl/spram_initiator.sv
// Initiator for a single-port read-first RAM with a one-cycle registered read port.
// Optionally clears the RAM after reset, then serves an in-order valid/ready request stream.
module spram_initiator #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           DEPTH      = 256,
   parameter int unsigned           RESP_DEPTH = 4,
   parameter bit                    INIT_EN    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int unsigned          ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  init_done_o,
   output logic                  ram_write_en_o,
   output logic                  ram_read_en_o,
   output logic [ADDR_W-1:0]     ram_address_o,
   output logic [DATA_WIDTH-1:0] ram_data_in_o,
   input  logic [DATA_WIDTH-1:0] ram_data_out_i
);

   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
   localparam int unsigned CLR_W = ADDR_W + 1;

   localparam logic [CLR_W-1:0] DepthC     = CLR_W'(DEPTH);
   localparam logic [CNT_W-1:0] RespDepthC = CNT_W'(RESP_DEPTH);
   localparam logic [PTR_W-1:0] PtrMax     = PTR_W'(RESP_DEPTH - 1);

   typedef enum logic {StClear, StRun} state_e;

   state_e                  state_q;
   logic [CLR_W-1:0]        clr_cnt_q;
   logic                    ram_write_en_q, ram_read_en_q;
   logic [ADDR_W-1:0]       ram_address_q;
   logic [DATA_WIDTH-1:0]   ram_data_in_q;

   logic                    rd_pend1_q, rd_pend2_q, rd_oob1_q, rd_oob2_q;
   logic [CNT_W-1:0]        outstanding_q, outstanding_d;

   logic [DATA_WIDTH-1:0]   fifo_mem_q [RESP_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;

   logic                    addr_ok, accept, rd_acc, pop, push;
   logic [DATA_WIDTH-1:0]   push_data;

   assign addr_ok   = {1'b0, req_addr_i} < DepthC;
   assign accept    = req_valid_i && req_ready_o;
   assign rd_acc    = accept && !req_we_i;
   assign pop       = resp_valid_o && resp_ready_i;
   assign push      = rd_pend2_q;
   assign push_data = rd_oob2_q ? '0 : ram_data_out_i;

   assign init_done_o    = (state_q == StRun);
   assign req_ready_o    = (state_q == StRun) && (outstanding_q < RespDepthC);
   assign resp_valid_o   = (fifo_cnt_q != '0);
   assign resp_rdata_o   = fifo_mem_q[rd_ptr_q];
   assign ram_write_en_o = ram_write_en_q;
   assign ram_read_en_o  = ram_read_en_q;
   assign ram_address_o  = ram_address_q;
   assign ram_data_in_o  = ram_data_in_q;

   // Without INIT_EN the counter starts exhausted, so the FSM leaves StClear on the first edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StClear;
         clr_cnt_q      <= INIT_EN ? '0 : DepthC;
         ram_write_en_q <= 1'b0;
         ram_read_en_q  <= 1'b0;
         ram_address_q  <= '0;
         ram_data_in_q  <= '0;
      end else begin
         unique case (state_q)
            StClear: begin
               ram_read_en_q <= 1'b0;
               if (clr_cnt_q == DepthC) begin
                  state_q        <= StRun;
                  ram_write_en_q <= 1'b0;
               end else begin
                  ram_write_en_q <= 1'b1;
                  ram_address_q  <= clr_cnt_q[ADDR_W-1:0];
                  ram_data_in_q  <= INIT_VALUE;
                  clr_cnt_q      <= clr_cnt_q + CLR_W'(1);
               end
            end
            StRun: begin
               ram_write_en_q <= accept && req_we_i && addr_ok;
               ram_read_en_q  <= rd_acc && addr_ok;
               if (accept && addr_ok) ram_address_q <= req_addr_i;
               if (accept && req_we_i && addr_ok) ram_data_in_q <= req_wdata_i;
            end
            default: state_q <= StClear;
         endcase
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (rd_acc && !pop) outstanding_d = outstanding_q + CNT_W'(1);
      else if (pop && !rd_acc) outstanding_d = outstanding_q - CNT_W'(1);
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      else if (pop && !push) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
   end

   // Read pipeline: stage 1 is the strobe cycle, stage 2 is when data_out is valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_pend1_q    <= 1'b0;
         rd_pend2_q    <= 1'b0;
         rd_oob1_q     <= 1'b0;
         rd_oob2_q     <= 1'b0;
         outstanding_q <= '0;
         fifo_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < RESP_DEPTH; i++) fifo_mem_q[i] <= '0;
      end else begin
         rd_pend1_q    <= rd_acc;
         rd_oob1_q     <= !addr_ok;
         rd_pend2_q    <= rd_pend1_q;
         rd_oob2_q     <= rd_oob1_q;
         outstanding_q <= outstanding_d;
         fifo_cnt_q    <= fifo_cnt_d;
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PTR_W'(1);
      end
   end

endmodule

// File: tb/tb_spram_initiator.sv
// Randomized scoreboard bench for spram_initiator with a read-first RAM model and
// an array-based reference memory.
module tb_spram_initiator;
   localparam int unsigned DW = 8;
   localparam int unsigned DEPTH = 12;
   localparam int unsigned RD = 4;
   localparam int unsigned AW = 4;
   localparam logic [DW-1:0] IV = 8'hA5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_we = 1'b0, req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid, resp_ready = 1'b0;
   logic [DW-1:0] resp_rdata;
   logic          init_done, ram_we, ram_re;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;

   spram_initiator #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESP_DEPTH(RD), .INIT_EN(1'b1), .INIT_VALUE(IV)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
      .init_done_o(init_done),
      .ram_write_en_o(ram_we), .ram_read_en_o(ram_re), .ram_address_o(ram_addr),
      .ram_data_in_o(ram_din), .ram_data_out_i(ram_dout)
   );

   always #5 clk = ~clk;

   // Read-first RAM with registered output.
   logic [DW-1:0] ram [16];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      if (ram_re) ram_dout <= ram[ram_addr];
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   acc;
      bit            chk;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ref_mem [DEPTH];
   bit            lat_chk = 1'b0, rr_rand = 1'b0, rr_fix = 1'b0;
   int            vectors = 0, miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fix;

   // Monitor samples just after the falling edge so resp_ready has settled.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         chk("one_strobe", {31'b0, ram_we && ram_re}, 0);
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
               e = sb.pop_front();
               chk("resp_data", resp_rdata, e.data);
               if (e.chk) chk("resp_latency", cyc, e.acc + 2);
            end
         end
      end
   end

   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int unsigned max_wait, output bit ok);
      exp_t e;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; ok = 1'b0;
      for (int unsigned n = 0; n < max_wait; n++) begin
         if (req_ready) begin
            ok = 1'b1;
            if (we) begin
               if (a < DEPTH) ref_mem[a] = d;
            end else begin
               e.data = (a < DEPTH) ? ref_mem[a] : '0;
               e.acc  = cyc + 1;
               e.chk  = lat_chk;
               sb.push_back(e);
            end
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit ok;
      issue(we, a, d, 200, ok);
      chk("req_accept", {31'b0, ok}, 1);
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      rr_fix = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
   endtask

   // Releases reset and follows the clear sweep until init_done.
   task automatic sweep_check();
      int unsigned c0, first = 0, done_c = 0, nwr = 0;
      bit seen = 1'b0, saw_valid = 1'b0, bad = 1'b0, done = 1'b0;
      rr_rand = 1'b0; rr_fix = 1'b1;
      c0 = cyc;
      rst = 1'b0;
      for (int i = 0; i < DEPTH + 20; i++) begin
         @(negedge clk);
         if (resp_valid) saw_valid = 1'b1;
         if (ram_we) begin
            if (!seen) begin
               seen = 1'b1; first = cyc;
               chk("clear_first_addr", ram_addr, 0);
            end
            if (ram_din !== IV || ram_addr !== AW'(nwr)) bad = 1'b1;
            nwr++;
         end
         if (init_done) begin
            done = 1'b1; done_c = cyc;
            break;
         end
      end
      chk("init_done_seen", {31'b0, done}, 1);
      chk("clear_start_cycle", first, c0 + 1);
      chk("init_done_delay", done_c - first, DEPTH);
      chk("clear_write_count", nwr, DEPTH);
      chk("clear_sweep_ok", {31'b0, bad}, 0);
      chk("no_stale_resp", {31'b0, saw_valid}, 0);
      chk("req_ready_after_init", {31'b0, req_ready}, 1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
   endtask

   task automatic backpressure(input logic [AW-1:0] base);
      bit ok;
      int unsigned nacc = 0, i = 0;
      rr_fix = 1'b0;
      @(negedge clk);
      while (i < 6) begin
         issue(1'b0, base + AW'(i), '0, 6, ok);
         if (!ok) break;
         nacc++; i++;
      end
      chk("bp_accepted", nacc, RD);
      chk("bp_req_ready_low", {31'b0, req_ready}, 0);
      rr_fix = 1'b1;
      while (i < 6) begin
         send(1'b0, base + AW'(i), '0);
         i++;
      end
      idle();
      drain();
   endtask

   initial begin
      bit we;
      logic [AW-1:0] a;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_init_done", {31'b0, init_done}, 0);
      chk("rst_ram_we", {31'b0, ram_we}, 0);
      chk("rst_ram_re", {31'b0, ram_re}, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);

      sweep_check();

      lat_chk = 1'b1;
      for (int i = 0; i < DEPTH; i++) send(1'b0, AW'(i), '0);
      idle();
      drain();

      send(1'b1, 4'd3, 8'h11);
      chk("wr_strobe", {31'b0, ram_we}, 1);
      chk("wr_addr", ram_addr, 3);
      chk("wr_data", ram_din, 8'h11);
      send(1'b1, 4'd4, 8'h22);
      send(1'b0, 4'd3, '0);
      chk("rd_strobe", {31'b0, ram_re}, 1);
      send(1'b0, 4'd4, '0);
      idle();
      drain();
      lat_chk = 1'b0;

      for (int i = 5; i <= 10; i++) send(1'b1, AW'(i), 8'h30 + DW'(i));
      idle();
      backpressure(4'd5);

      send(1'b1, 4'd13, 8'h7F);
      idle();
      chk("oob_wr_no_strobe", {31'b0, ram_we}, 0);
      send(1'b0, 4'd13, '0);
      idle();
      chk("oob_rd_no_strobe", {31'b0, ram_re}, 0);
      send(1'b0, 4'd11, '0);
      idle();
      chk("inrange_rd_strobe", {31'b0, ram_re}, 1);
      drain();

      rr_fix = 1'b0;
      send(1'b0, 4'd3, '0);
      send(1'b0, 4'd4, '0);
      send(1'b0, 4'd5, '0);
      idle();
      rst = 1'b1;
      sb.delete();
      repeat (2) @(negedge clk);
      chk("midrst_resp_valid", {31'b0, resp_valid}, 0);
      chk("midrst_req_ready", {31'b0, req_ready}, 0);
      sweep_check();
      backpressure(4'd0);

      rr_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 15));
         send(we, a, DW'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(negedge clk);
         end
      end
      idle();
      rr_rand = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
